// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback arbiter: source indices, default widths
// and the holding-slot entry type.
package writeback_pkg;

  localparam int WB_NUM_SOURCES = 4;
  localparam int WB_DATA_W      = 16;
  localparam int WB_REGADDR_W   = 4;
  localparam int WB_TAG_W       = 6;

  localparam int WB_SRC_ALU0   = 0;
  localparam int WB_SRC_ALU1   = 1;
  localparam int WB_SRC_BRANCH = 2;
  localparam int WB_SRC_MEM    = 3;

  typedef struct packed {
    logic [WB_REGADDR_W-1:0] reg_addr;
    logic [WB_DATA_W-1:0]    data;
    logic [WB_TAG_W-1:0]     tag;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_rr.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (mod N) and
// grants the first requester; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  always_comb begin : search
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Collects execute-unit results into per-source holding slots and serialises them
// round-robin onto the register-file write port. Optional: WRITEBACK_R0_DISCARD_EN.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int DATABITWIDTH    = WB_DATA_W,
  parameter int REGADDRBITWIDTH = WB_REGADDR_W,
  parameter int TAGBITWIDTH     = WB_TAG_W,
  parameter int NUMSOURCES      = WB_NUM_SOURCES
) (
  input  logic                                  clk,
  input  logic                                  clk_en,
  input  logic                                  sync_rst,
  input  logic [NUMSOURCES-1:0]                 Src_Valid,
  output logic [NUMSOURCES-1:0]                 Src_Ready,
  input  logic [NUMSOURCES*REGADDRBITWIDTH-1:0] Src_RegAddr,
  input  logic [NUMSOURCES*DATABITWIDTH-1:0]    Src_Data,
  input  logic [NUMSOURCES*TAGBITWIDTH-1:0]     Src_Tag,
  output logic                                  Write_En,
  output logic [REGADDRBITWIDTH-1:0]            Write_Address,
  output logic [DATABITWIDTH-1:0]               Write_Data,
  output logic [DATABITWIDTH-1:0]               Forward0Data,
  output logic                                  Forward0Valid,
  output logic [REGADDRBITWIDTH-1:0]            Forward0RegAddr,
  output logic                                  TagRetireValid,
  output logic [TAGBITWIDTH-1:0]                TagRetire,
  output logic                                  Busy
);

  localparam int IDX_W = (NUMSOURCES > 1) ? $clog2(NUMSOURCES) : 1;

  logic [NUMSOURCES-1:0] occupied;
  wb_entry_t             slot     [NUMSOURCES];
  wb_entry_t             incoming [NUMSOURCES];
  logic [IDX_W-1:0]      ptr;

  logic                  active;
  logic [NUMSOURCES-1:0] req;
  logic [NUMSOURCES-1:0] grant;
  logic [NUMSOURCES-1:0] accept;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_grant;
  wb_entry_t             sel;

  // Reset dominates clk_en: nothing is offered, accepted or granted while it is high.
  assign active    = clk_en & ~sync_rst;
  assign req       = occupied & {NUMSOURCES{active}};
  assign Src_Ready = {NUMSOURCES{active}} & (~occupied | grant);
  assign accept    = Src_Valid & Src_Ready;
  assign Busy      = |occupied;
  assign sel       = slot[grant_idx];

  always_comb begin
    for (int i = 0; i < NUMSOURCES; i++) begin
      incoming[i].reg_addr = Src_RegAddr[i*REGADDRBITWIDTH +: REGADDRBITWIDTH];
      incoming[i].data     = Src_Data[i*DATABITWIDTH +: DATABITWIDTH];
      incoming[i].tag      = Src_Tag[i*TAGBITWIDTH +: TAGBITWIDTH];
    end
  end

  rr_arbiter #(.N(NUMSOURCES)) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      occupied       <= '0;
      ptr            <= IDX_W'(NUMSOURCES - 1);
      Write_En       <= 1'b0;
      Write_Address  <= '0;
      Write_Data     <= '0;
      TagRetireValid <= 1'b0;
      TagRetire      <= '0;
      for (int i = 0; i < NUMSOURCES; i++) slot[i] <= '0;
    end else if (clk_en) begin
      // A granted slot may be refilled on the same edge it drains.
      for (int i = 0; i < NUMSOURCES; i++) begin
        if (accept[i]) begin
          occupied[i] <= 1'b1;
          slot[i]     <= incoming[i];
        end else if (grant[i]) begin
          occupied[i] <= 1'b0;
        end
      end
      if (any_grant) begin
        ptr            <= grant_idx;
        TagRetireValid <= 1'b1;
        TagRetire      <= sel.tag;
        Write_Address  <= sel.reg_addr;
        Write_Data     <= sel.data;
`ifdef WRITEBACK_R0_DISCARD_EN
        Write_En       <= (sel.reg_addr != '0);
`else
        Write_En       <= 1'b1;
`endif
      end else begin
        Write_En       <= 1'b0;
        TagRetireValid <= 1'b0;
      end
    end
  end

  assign Forward0Data    = Write_Data;
  assign Forward0Valid   = Write_En;
  assign Forward0RegAddr = Write_Address;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter against a round-robin
// reference model of pending results per source.
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int TW = 6;
  localparam int EW = AW + DW + TW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clk_en;
  logic sync_rst;
  always #5 clk = ~clk;

  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*AW-1:0] src_reg_addr;
  logic [N*DW-1:0] src_data;
  logic [N*TW-1:0] src_tag;
  logic            write_en;
  logic [AW-1:0]   write_address;
  logic [DW-1:0]   write_data;
  logic [DW-1:0]   forward0_data;
  logic            forward0_valid;
  logic [AW-1:0]   forward0_reg_addr;
  logic            tag_retire_valid;
  logic [TW-1:0]   tag_retire;
  logic            busy;

  writeback_arbiter dut (
    .clk             (clk),
    .clk_en          (clk_en),
    .sync_rst        (sync_rst),
    .Src_Valid       (src_valid),
    .Src_Ready       (src_ready),
    .Src_RegAddr     (src_reg_addr),
    .Src_Data        (src_data),
    .Src_Tag         (src_tag),
    .Write_En        (write_en),
    .Write_Address   (write_address),
    .Write_Data      (write_data),
    .Forward0Data    (forward0_data),
    .Forward0Valid   (forward0_valid),
    .Forward0RegAddr (forward0_reg_addr),
    .TagRetireValid  (tag_retire_valid),
    .TagRetire       (tag_retire),
    .Busy            (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver state: what each source is offering ----------------
  bit            offer    [N];
  logic [AW-1:0] off_addr [N];
  logic [DW-1:0] off_data [N];
  logic [TW-1:0] off_tag  [N];

  // ---------------- reference model ----------------
  bit            m_known;
  bit            m_pending [N];
  logic [AW-1:0] m_addr    [N];
  logic [DW-1:0] m_data    [N];
  logic [TW-1:0] m_tag     [N];
  int            m_last;
  logic          e_we, e_trv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [TW-1:0] e_tag;
  logic [EW-1:0] exp_q[$];

  task automatic set_offer(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [TW-1:0] t);
    offer[s]    = 1'b1;
    off_addr[s] = a;
    off_data[s] = d;
    off_tag[s]  = t;
  endtask

  // One clock cycle: drive at negedge, check handshake, advance model, check outputs.
  task automatic step(input bit en, input bit rst);
    int  win;
    bit  any_pending;
    bit  exp_ready [N];
    logic [EW-1:0] rec;
    for (int i = 0; i < N; i++) begin
      src_valid[i]               = offer[i];
      src_reg_addr[i*AW +: AW]   = off_addr[i];
      src_data[i*DW +: DW]       = off_data[i];
      src_tag[i*TW +: TW]        = off_tag[i];
    end
    clk_en   = en;
    sync_rst = rst;
    #1;
    win = -1;
    any_pending = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int s;
      s = (m_last + k) % N;
      if (m_pending[s]) any_pending = 1'b1;
      if (en && !rst && win < 0 && m_pending[s]) win = s;
    end
    for (int i = 0; i < N; i++) begin
      exp_ready[i] = en && !rst && (!m_pending[i] || win == i);
      check("src_ready", 32'(src_ready[i]), 32'(exp_ready[i]));
    end
    if (m_known) check("busy", 32'(busy), 32'(any_pending));

    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_pending[i] = 1'b0;
      m_last = N - 1;
      {e_we, e_trv, e_addr, e_data, e_tag} = '0;
      m_known = 1'b1;
    end else if (en) begin
      if (win >= 0) begin
        e_trv  = 1'b1;
        e_addr = m_addr[win];
        e_data = m_data[win];
        e_tag  = m_tag[win];
`ifdef WRITEBACK_R0_DISCARD_EN
        e_we   = (m_addr[win] != 0);
`else
        e_we   = 1'b1;
`endif
        m_pending[win] = 1'b0;
        m_last = win;
        exp_q.push_back({e_addr, e_data, e_tag});
      end else begin
        e_we  = 1'b0;
        e_trv = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (offer[i] && exp_ready[i]) begin
          m_pending[i] = 1'b1;
          m_addr[i]    = off_addr[i];
          m_data[i]    = off_data[i];
          m_tag[i]     = off_tag[i];
          offer[i]     = 1'b0;
        end
      end
    end
    #1;
    if (m_known) begin
      check("write_en", 32'(write_en), 32'(e_we));
      check("tag_retire_valid", 32'(tag_retire_valid), 32'(e_trv));
      check("write_address", 32'(write_address), 32'(e_addr));
      check("write_data", 32'(write_data), 32'(e_data));
      check("tag_retire", 32'(tag_retire), 32'(e_tag));
      check("fwd_valid", 32'(forward0_valid), 32'(e_we));
      check("fwd_data", 32'(forward0_data), 32'(e_data));
      check("fwd_addr", 32'(forward0_reg_addr), 32'(e_addr));
    end
    if (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      check("wb_record", 32'({write_address, write_data, tag_retire}), 32'(rec));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) offer[i] = 1'b0;
    step(1'b1, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt0, cnt2;
    logic [AW-1:0] prev_addr;
    bit have_prev;
    m_known = 1'b0;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) begin
      offer[i] = 1'b0; off_addr[i] = '0; off_data[i] = '0; off_tag[i] = '0;
      m_pending[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; m_tag[i] = '0;
    end
    {e_we, e_trv, e_addr, e_data, e_tag} = '0;
    clk_en = 1'b0; sync_rst = 1'b1;
    src_valid = '0; src_reg_addr = '0; src_data = '0; src_tag = '0;
    @(negedge clk);

    // Reset with every source valid: nothing accepted, source 0 first afterwards.
    for (int i = 0; i < N; i++) set_offer(i, AW'(4 + i), DW'(16'h0100 + i), TW'(i));
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("reset_write_en", 32'(write_en), 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("first_grant_addr", 32'(write_address), 32'd4);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);

    // Single source, two cycles to the write port.
    do_reset();
    set_offer(0, 4'd3, 16'h1234, 6'd5);
    step(1'b1, 1'b0);
    check("single_no_early_we", 32'(write_en), 32'd0);
    step(1'b1, 1'b0);
    check("single_we", 32'(write_en), 32'd1);
    check("single_addr", 32'(write_address), 32'd3);
    check("single_data", 32'(write_data), 32'h1234);
    check("single_tag", 32'(tag_retire), 32'd5);
    check("single_fwd", 32'(forward0_data), 32'h1234);
    step(1'b1, 1'b0);

    // Contention: all four at once, then refills as each slot is granted.
    do_reset();
    for (int i = 0; i < N; i++) set_offer(i, AW'(8 + i), DW'(16'h00A0 + i), TW'(i));
    step(1'b1, 1'b0);
    for (int i = 0; i < N; i++) set_offer(i, AW'(12 + i), DW'(16'h00B0 + i), TW'(16 + i));
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0);
      check("contention_order", 32'(write_data), (k < 4) ? 32'(16'h00A0 + k) : 32'(16'h00B0 + k - 4));
    end

    // Fairness: sources 0 and 2 continuously valid.
    do_reset();
    cnt0 = 0; cnt2 = 0; have_prev = 1'b0; prev_addr = '0;
    for (int c = 0; c < 22; c++) begin
      if (!offer[0]) set_offer(0, 4'd1, DW'($urandom), TW'($urandom));
      if (!offer[2]) set_offer(2, 4'd2, DW'($urandom), TW'($urandom));
      step(1'b1, 1'b0);
      if (tag_retire_valid) begin
        if (write_address == 4'd1) cnt0++;
        if (write_address == 4'd2) cnt2++;
        if (have_prev) check("fair_alternate", 32'(write_address != prev_addr), 32'd1);
        prev_addr = write_address;
        have_prev = 1'b1;
      end
    end
    check("fair_src0", 32'(cnt0 >= 9), 32'd1);
    check("fair_src2", 32'(cnt2 >= 9), 32'd1);

    // clk_en low with two slots occupied: everything frozen.
    do_reset();
    set_offer(1, 4'd5, 16'h5151, 6'd11);
    set_offer(3, 4'd6, 16'h6363, 6'd13);
    step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("gate_first", 32'(write_address), 32'd5);
    step(1'b1, 1'b0);
    check("gate_second", 32'(write_address), 32'd6);
    step(1'b1, 1'b0);

    // Register 0 write.
    do_reset();
    set_offer(1, 4'd0, 16'h5555, 6'd9);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("r0_trv", 32'(tag_retire_valid), 32'd1);
    check("r0_tag", 32'(tag_retire), 32'd9);
`ifdef WRITEBACK_R0_DISCARD_EN
    check("r0_we", 32'(write_en), 32'd0);
`else
    check("r0_we", 32'(write_en), 32'd1);
    check("r0_addr", 32'(write_address), 32'd0);
`endif

    // Random traffic with clk_en dropouts and occasional mid-flight reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit en, rst;
      for (int i = 0; i < N; i++)
        if (!offer[i] && $urandom_range(0, 99) < 40)
          set_offer(i, AW'($urandom_range(0, 15)), DW'($urandom), TW'($urandom));
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step(en, rst);
      if (rst) for (int i = 0; i < N; i++) offer[i] = 1'b0;
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0);
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
